// File: rtl/aim65_tty_pkg.sv
// Shared types and constants for the AIM65 TTY host-side transmitter.
// Frame states and baud-divider helper live here.
package aim65_tty_pkg;

   localparam int DEF_CLK_HZ = 1000000;
   localparam int DEF_BAUD   = 9600;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tty_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/aim65_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty flags and level.
// Read data falls through combinationally from the head entry.
module aim65_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             cpu_clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_nxt;

   assign rd_data   = mem[rd_ptr];
   assign level_nxt = level + LW'(wr) - LW'(rd);

   always_ff @(posedge cpu_clk) begin
      if (wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

endmodule

// File: rtl/aim65_tty_tx.sv
// Buffered async serial transmitter feeding the AIM65 TTY receive line.
// Frames are start, LSB-first data, stop bits; back-to-back when data waits.
module aim65_tty_tx
   import aim65_tty_pkg::*;
#(
   parameter int CLK_HZ     = DEF_CLK_HZ,
   parameter int BAUD       = DEF_BAUD,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 2,
   parameter int FIFO_DEPTH = 16,
   localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          cpu_clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [7:0]    tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          serial_out,
   output logic          busy,
   output logic [LW-1:0] fifo_level,
   output logic          overflow
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB + 1);

   tty_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          line_d;
   logic          bit_end;
   logic          wr, rd;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [LW-1:0] level_nxt;

   assign tx_ready  = ~fifo_full;
   assign wr        = tx_valid & tx_ready;
   assign bit_end   = (cnt_q == CW'(CPB - 1));
   assign level_nxt = fifo_level + LW'(wr) - LW'(rd);

   aim65_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .wr      (wr),
      .wr_data (tx_data),
      .rd      (rd),
      .rd_data (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      rd      = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (enable && !fifo_empty) begin
               rd      = 1'b1;
               shift_d = fifo_dout;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  // chain straight into the next frame when a byte is waiting
                  if (enable && !fifo_empty) begin
                     rd      = 1'b1;
                     shift_d = fifo_dout;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_comb begin
      line_d = 1'b1;
      unique case (state_d)
         IDLE:  line_d = 1'b1;
         START: line_d = 1'b0;
         DATA:  line_d = shift_d[0];
         STOP:  line_d = 1'b1;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         serial_out <= 1'b1;
         busy       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         serial_out <= line_d;
         busy       <= (state_d != IDLE) || (level_nxt != '0);
         if (tx_valid && !tx_ready) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aim65_tty_tx.sv
// Scoreboard bench for aim65_tty_tx: line decoder checks bytes, timing, flags.
// A second instance covers the 7-data-bit, 1-stop-bit frame format.
module tb_aim65_tty_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] tx_data, tx_data7;
   logic       tx_valid, tx_valid7;
   logic       tx_ready, tx_ready7;
   logic       so, so7;
   logic       busy, busy7;
   logic [4:0] level, level7;
   logic       overflow, overflow7;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   bit         mon_en = 1'b1;
   bit         mon_busy = 1'b0;
   logic [7:0] q8[$];
   logic [7:0] q7[$];
   int         starts[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aim65_tty_tx #(
      .CLK_HZ(40), .BAUD(10), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(16)
   ) dut (
      .cpu_clk    (clk),
      .reset      (reset),
      .enable     (enable),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .serial_out (so),
      .busy       (busy),
      .fifo_level (level),
      .overflow   (overflow)
   );

   aim65_tty_tx #(
      .CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut7 (
      .cpu_clk    (clk),
      .reset      (reset),
      .enable     (enable),
      .tx_data    (tx_data7),
      .tx_valid   (tx_valid7),
      .tx_ready   (tx_ready7),
      .serial_out (so7),
      .busy       (busy7),
      .fifo_level (level7),
      .overflow   (overflow7)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // called at the first negedge showing the start bit; samples mid-bit
   task automatic decode(input bit which, input int db, input int sb,
                         output logic [7:0] b);
      b = '0;
      repeat (2) @(negedge clk);
      chk("start_bit", which ? so7 : so, 1'b0);
      for (int i = 0; i < db; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = which ? so7 : so;
      end
      for (int i = 0; i < sb; i++) begin
         repeat (CPB) @(negedge clk);
         chk("stop_bit", which ? so7 : so, 1'b1);
      end
   endtask

   initial begin : mon8
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && !reset && so === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            decode(1'b0, 8, 2, b);
            if (q8.size() == 0) chk("extra_frame", 1, 0);
            else chk("rx_byte", b, q8.pop_front());
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : mon7
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!reset && so7 === 1'b0) begin
            decode(1'b1, 7, 1, b);
            if (q7.size() == 0) chk("extra_frame7", 1, 0);
            else chk("rx_byte7", b, q7.pop_front());
         end
      end
   end

   task automatic push(input logic [7:0] b, input bit acc);
      tx_valid = 1'b1;
      tx_data  = b;
      if (acc) q8.push_back(b);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy && !busy7 && !mon_busy && q8.size() == 0 && q7.size() == 0)
            break;
      end
      chk("drain_in_budget", k < budget, 1'b1);
   endtask

   initial begin : main
      int n;
      int k;
      int lows;
      reset     = 1'b1;
      enable    = 1'b1;
      tx_valid  = 1'b0;
      tx_valid7 = 1'b0;
      tx_data   = '0;
      tx_data7  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_serial", so, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_level", level, 5'd0);
      chk("rst_ovf", overflow, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // single byte: exact start latency and frame length
      starts.delete();
      push(8'h55, 1'b1);
      n = cyc;
      @(negedge clk);
      chk("t1_level", level, 5'd1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_idle_line", so, 1'b1);
      for (k = 1; k < 100; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("t1_start_low", so, 1'b0);
            chk("t1_popped", level, 5'd0);
         end
         if (!busy) break;
      end
      chk("t1_busy_fall", k, 45);
      wait_drain(100);
      if (starts.size() > 0) chk("t1_start_lat", starts[0] - n, 1);
      else chk("t1_no_frame", 0, 1);

      // back-to-back frames
      starts.delete();
      push(8'h41, 1'b1);
      push(8'h42, 1'b1);
      push(8'h43, 1'b1);
      @(negedge clk);
      chk("t2_peak_level", level, 5'd2);
      wait_drain(300);
      chk("t2_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         chk("t2_gap01", starts[1] - starts[0], 44);
         chk("t2_gap12", starts[2] - starts[1], 44);
      end

      // fill with enable low, overflow, push-at-full during a pop
      enable = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i * 7), 1'b1);
      @(negedge clk);
      chk("t3_full_level", level, 5'd16);
      chk("t3_not_ready", tx_ready, 1'b0);
      chk("t3_line_idle", so, 1'b1);
      chk("t3_busy", busy, 1'b1);
      chk("t3_no_ovf_yet", overflow, 1'b0);
      push(8'h5A, 1'b0);
      @(negedge clk);
      chk("t3_ovf_set", overflow, 1'b1);
      chk("t3_level_hold", level, 5'd16);
      enable = 1'b1;
      push(8'hEE, 1'b0);
      @(negedge clk);
      chk("t3_pop_drop_level", level, 5'd15);
      chk("t3_ready_again", tx_ready, 1'b1);
      push(8'h99, 1'b1);
      @(negedge clk);
      chk("t3_refill", level, 5'd16);
      wait_drain(900);
      chk("t3_ovf_sticky", overflow, 1'b1);

      // reset in the middle of a data bit
      mon_en = 1'b0;
      push(8'hA5, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t4_pre_rst_bit1", so, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t4_rst_line", so, 1'b1);
      chk("t4_rst_level", level, 5'd0);
      chk("t4_rst_busy", busy, 1'b0);
      chk("t4_rst_ovf", overflow, 1'b0);
      chk("t4_rst_ready", tx_ready, 1'b1);
      reset = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (so !== 1'b1) lows++;
      end
      chk("t4_no_edges", lows, 0);
      mon_en = 1'b1;

      // 7 data bits, 1 stop bit: bit 7 dropped, 36-cycle frame
      @(posedge clk);
      #1;
      tx_valid7 = 1'b1;
      tx_data7  = 8'hC1;
      q7.push_back(8'h41);
      @(posedge clk);
      #1;
      tx_valid7 = 1'b0;
      @(negedge clk);
      chk("t5_level7", level7, 5'd1);
      for (k = 1; k < 100; k++) begin
         @(negedge clk);
         if (!busy7) break;
      end
      chk("t5_busy7_fall", k, 37);
      wait_drain(100);
      chk("t5_ovf7", overflow7, 1'b0);
      chk("t5_ready7", tx_ready7, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
